// File: rtl/data_cache_if.sv
// CPU-side MEM-stage request bus and line-wide backing-memory channel
// for the data cache, bundled with cache (slave) and requester (master) views.
interface data_cache_if #(
  parameter int LINE_BITS = 128
);
  logic                 is_input_valid;
  logic [31:0]          addr;
  logic                 mem_rw;
  logic [31:0]          din;
  logic                 is_ready;
  logic                 is_output_valid;
  logic [31:0]          dout;
  logic                 is_hit;
  logic                 mem_req_valid;
  logic                 mem_req_write;
  logic [31:0]          mem_req_addr;
  logic [LINE_BITS-1:0] mem_req_wdata;
  logic                 mem_req_ready;
  logic                 mem_resp_valid;
  logic [LINE_BITS-1:0] mem_resp_rdata;

  modport slave (
    input  is_input_valid, addr, mem_rw, din,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata,
    output is_ready, is_output_valid, dout, is_hit,
    output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );

  modport master (
    output is_input_valid, addr, mem_rw, din,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata,
    input  is_ready, is_output_valid, dout, is_hit,
    input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata
  );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Misses refill whole lines; dirty victims are written back first.
module data_cache #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_SETS   = 16
) (
  input  logic        clk,
  input  logic        reset,
  data_cache_if.slave bus
);
  localparam int LB = 32 * LINE_WORDS;
  localparam int OB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = 32 - OB - IB - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_CMP, S_WB, S_AREQ, S_AWAIT
  } state_t;

  state_t r_state, w_next;

  logic [31:0]         r_addr;
  logic [31:0]         r_din;
  logic                r_rw;
  logic                r_miss;
  logic [31:0]         r_dout;
  logic [NUM_SETS-1:0] r_valid;
  logic [NUM_SETS-1:0] r_dirty;
  logic [TB-1:0]       r_tag  [NUM_SETS];
  logic [LB-1:0]       r_data [NUM_SETS];

  logic [OB-1:0] w_off;
  logic [IB-1:0] w_idx;
  logic [TB-1:0] w_tag;
  logic [LB-1:0] w_line;
  logic [31:0]   w_word;
  logic          w_hit;

  assign w_off  = r_addr[OB+1:2];
  assign w_idx  = r_addr[OB+IB+1:OB+2];
  assign w_tag  = r_addr[31:OB+IB+2];
  assign w_line = r_data[w_idx];
  assign w_word = w_line[{w_off, 5'b0} +: 32];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next              = r_state;
    bus.is_ready        = 1'b0;
    bus.is_output_valid = 1'b0;
    bus.is_hit          = 1'b0;
    bus.dout            = r_dout;
    bus.mem_req_valid   = 1'b0;
    bus.mem_req_write   = 1'b0;
    bus.mem_req_addr    = '0;
    bus.mem_req_wdata   = '0;
    unique case (r_state)
      S_IDLE: begin
        bus.is_ready = 1'b1;
        if (bus.is_input_valid) w_next = S_CMP;
      end
      S_CMP: begin
        if (w_hit) begin
          bus.is_output_valid = 1'b1;
          bus.dout            = w_word;
          bus.is_hit          = !r_miss;
          w_next              = S_IDLE;
        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
          w_next = S_WB;
        end else begin
          w_next = S_AREQ;
        end
      end
      S_WB: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_write = 1'b1;
        bus.mem_req_addr  = {r_tag[w_idx], w_idx, {(OB+2){1'b0}}};
        bus.mem_req_wdata = w_line;
        if (bus.mem_req_ready) w_next = S_AREQ;
      end
      S_AREQ: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {w_tag, w_idx, {(OB+2){1'b0}}};
        if (bus.mem_req_ready) w_next = S_AWAIT;
      end
      S_AWAIT: begin
        if (bus.mem_resp_valid) w_next = S_CMP;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
      r_miss  <= 1'b0;
      r_dout  <= '0;
      r_addr  <= '0;
      r_din   <= '0;
      r_rw    <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.is_input_valid) begin
            r_addr <= bus.addr;
            r_din  <= bus.din;
            r_rw   <= bus.mem_rw;
            r_miss <= 1'b0;
          end
        end
        S_CMP: begin
          if (w_hit) begin
            r_dout <= w_word;
            if (r_rw) r_dirty[w_idx] <= 1'b1;
          end else begin
            r_miss <= 1'b1;
          end
        end
        S_AWAIT: begin
          if (bus.mem_resp_valid) begin
            r_valid[w_idx] <= 1'b1;
            r_dirty[w_idx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // line storage carries no reset; valid bits gate its use
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_CMP && w_hit && r_rw)
        r_data[w_idx][{w_off, 5'b0} +: 32] <= r_din;
      if (r_state == S_AWAIT && bus.mem_resp_valid) begin
        r_data[w_idx] <= bus.mem_resp_rdata;
        r_tag[w_idx]  <= w_tag;
      end
    end
  end
endmodule

// File: tb/tb_data_cache.sv
// Random and directed checks of data_cache against a flat-memory
// reference with a per-set residency model and a backing-memory responder.
module tb_data_cache;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_cache_if #(.LINE_BITS(128)) bus();

  data_cache #(.LINE_WORDS(4), .NUM_SETS(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [127:0] d;
  } req_t;

  int n_vec = 0;
  int n_err = 0;

  req_t         req_log[$];
  logic [127:0] bmem [logic [31:0]];
  logic [31:0]  arch [logic [31:0]];
  bit           mvalid [16];
  bit           mdirty [16];
  int           mtag   [16];

  int          ready_mode = 0;
  bit          resp_hold  = 0;
  bit          pend       = 0;
  logic [31:0] pend_a;
  int          dly;

  task automatic chk(input string tag, input logic [127:0] got,
                     input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] line_rd(input logic [31:0] base);
    logic [127:0] l;
    if (bmem.exists(base)) return bmem[base];
    for (int i = 0; i < 4; i++)
      l[i*32 +: 32] = (base + 32'(4*i)) * 32'h9E37_79B1 ^ 32'h5A5A_0F0F;
    return l;
  endfunction

  function automatic logic [31:0] arch_rd(input logic [31:0] a);
    logic [127:0] l;
    if (arch.exists(a)) return arch[a];
    l = line_rd(a & ~32'hF);
    return l[a[3:2]*32 +: 32];
  endfunction

  function automatic logic [127:0] arch_line(input logic [31:0] base);
    logic [127:0] l;
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = arch_rd(base + 32'(4*i));
    return l;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 0;
      mdirty[i] = 0;
      mtag[i]   = 0;
    end
    arch.delete();
  endfunction

  // backing memory: random ready, random response delay, stray responses
  initial begin : mem_model
    bit r, hs;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_rdata = '0;
    forever begin
      @(negedge clk);
      bus.mem_resp_valid = 1'b0;
      if (reset) begin
        pend = 0;
        bus.mem_req_ready = 1'b0;
        continue;
      end
      if (pend && !resp_hold) begin
        if (dly == 0) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_rdata = line_rd(pend_a);
          pend = 0;
        end else begin
          dly--;
        end
      end
      case (ready_mode)
        0:       r = ($urandom_range(2) != 0);
        1:       r = 1;
        default: r = 0;
      endcase
      bus.mem_req_ready = r;
      hs = bus.mem_req_valid && r;
      if (hs) begin
        req_log.push_back('{bus.mem_req_write, bus.mem_req_addr,
                           bus.mem_req_wdata});
        if (bus.mem_req_write) begin
          bmem[bus.mem_req_addr] = bus.mem_req_wdata;
        end else begin
          pend   = 1;
          pend_a = bus.mem_req_addr;
          dly    = $urandom_range(2);
        end
      end else if (!pend && !resp_hold && !bus.mem_resp_valid &&
                   $urandom_range(7) == 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_rdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  end

  // mode: 0 plain, 1 poke during writeback, 2 stall allocate, 3 abort
  task automatic txn(input logic [31:0] a, input logic rw,
                     input logic [31:0] d, input int mode,
                     output logic [31:0] gd, output logic gh);
    int s, nt, n0, cyc, nexp;
    bit eh, ewb, got;
    logic [31:0] vic, erd, rbase;
    logic [127:0] eline;
    s     = int'(a[7:4]);
    nt    = int'(a[31:8]);
    rbase = a & ~32'hF;
    eh    = mvalid[s] && mtag[s] == nt;
    ewb   = !eh && mvalid[s] && mdirty[s];
    vic   = (32'(mtag[s]) << 8) | (32'(s) << 4);
    eline = arch_line(vic);
    erd   = arch_rd(a & ~32'h3);
    n0    = req_log.size();
    gd    = '0;
    gh    = 1'b0;
    if (mode == 2) ready_mode = 2;
    cyc = 0;
    while (!bus.is_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_ready", bus.is_ready, 1);
    bus.is_input_valid = 1'b1;
    bus.addr   = a;
    bus.mem_rw = rw;
    bus.din    = d;
    @(negedge clk);
    bus.is_input_valid = 1'b0;
    bus.addr = $urandom;
    bus.din  = $urandom;
    cyc = 1;
    if (mode == 1) begin
      for (int k = 0; k < 50; k++) begin
        if (bus.mem_req_valid && bus.mem_req_write) break;
        @(negedge clk);
      end
      chk("wb_seen", bus.mem_req_valid && bus.mem_req_write, 1);
      bus.is_input_valid = 1'b1;
      bus.addr   = 32'h300;
      bus.mem_rw = 1'b0;
      @(negedge clk);
      bus.is_input_valid = 1'b0;
    end else if (mode == 2) begin
      @(negedge clk);
      for (int k = 0; k < 5; k++) begin
        chk("stall_valid", bus.mem_req_valid, 1);
        chk("stall_addr", bus.mem_req_addr, rbase);
        chk("stall_write", bus.mem_req_write, 0);
        chk("stall_ov", bus.is_output_valid, 0);
        chk("stall_ready", bus.is_ready, 0);
        @(negedge clk);
      end
      ready_mode = 0;
    end else if (mode == 3) begin
      ready_mode = 1;
      resp_hold  = 1;
      for (int k = 0; k < 50; k++) begin
        if (req_log.size() > n0) break;
        @(negedge clk);
      end
      chk("abort_req", req_log.size() - n0, 1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pend  = 0;
      chk("abort_ready", bus.is_ready, 1);
      chk("abort_ov", bus.is_output_valid, 0);
      chk("abort_mreq", bus.mem_req_valid, 0);
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        chk("abort_no_ov", bus.is_output_valid, 0);
      end
      resp_hold  = 0;
      ready_mode = 0;
      model_reset();
      return;
    end
    got = 0;
    for (int k = 0; k < 300; k++) begin
      if (bus.is_output_valid) begin
        got = 1;
        gd  = bus.dout;
        gh  = bus.is_hit;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk("ov_timeout", got, 1);
    chk("is_hit", gh, eh);
    if (eh && mode == 0) chk("hit_latency", cyc, 1);
    if (!rw) chk("dout", gd, erd);
    @(negedge clk);
    chk("ready_after", bus.is_ready, 1);
    chk("ov_pulse", bus.is_output_valid, 0);
    nexp = eh ? 0 : (ewb ? 2 : 1);
    chk("nreq", req_log.size() - n0, nexp);
    if (req_log.size() - n0 == nexp && nexp > 0) begin
      if (ewb) begin
        chk("wb_write", req_log[n0].w, 1);
        chk("wb_addr", req_log[n0].a, vic);
        chk("wb_data", req_log[n0].d, eline);
      end
      chk("rd_write", req_log[n0+nexp-1].w, 0);
      chk("rd_addr", req_log[n0+nexp-1].a, rbase);
    end
    mdirty[s] = (eh ? mdirty[s] : 0) | rw;
    mvalid[s] = 1;
    mtag[s]   = nt;
    if (rw) arch[a & ~32'h3] = d;
  endtask

  initial begin
    logic [31:0] gd, a;
    logic gh;
    int n;
    bus.is_input_valid = 1'b0;
    bus.addr   = '0;
    bus.mem_rw = 1'b0;
    bus.din    = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ready", bus.is_ready, 1);
    chk("rst_ov", bus.is_output_valid, 0);
    chk("rst_dout", bus.dout, 0);
    chk("rst_hit", bus.is_hit, 0);
    chk("rst_mreq", bus.mem_req_valid, 0);

    bmem[32'h100] = {32'd4, 32'd3, 32'd2, 32'd1};
    txn(32'h100, 0, 0, 0, gd, gh);
    chk("t1_dout", gd, 1);
    chk("t1_hit", gh, 0);
    txn(32'h104, 0, 0, 0, gd, gh);
    chk("t1b_dout", gd, 2);
    chk("t1b_hit", gh, 1);

    txn(32'h108, 1, 32'hDEAD_BEEF, 0, gd, gh);
    txn(32'h108, 0, 0, 0, gd, gh);
    chk("t2_dout", gd, 32'hDEAD_BEEF);
    chk("t2_hit", gh, 1);

    n = req_log.size();
    txn(32'h200, 0, 0, 0, gd, gh);
    chk("t3_hit", gh, 0);
    if (req_log.size() >= n + 1) begin
      chk("t3_wb_addr", req_log[n].a, 32'h100);
      chk("t3_wb_w2", req_log[n].d[95:64], 32'hDEAD_BEEF);
    end

    txn(32'h204, 1, 32'h1234_5678, 0, gd, gh);
    txn(32'h100, 0, 0, 1, gd, gh);
    n = req_log.size();
    repeat (4) @(negedge clk);
    chk("t6_no_extra", req_log.size(), n);

    txn(32'h500, 0, 0, 2, gd, gh);
    txn(32'h400, 0, 0, 3, gd, gh);
    txn(32'h100, 0, 0, 0, gd, gh);
    chk("t5_hit", gh, 0);

    for (int i = 0; i < 300; i++) begin
      a = {22'($urandom_range(3)), 4'($urandom), 4'($urandom), 2'b00};
      txn(a, 1'($urandom), $urandom, 0, gd, gh);
      if ($urandom_range(3) == 0) repeat ($urandom_range(3)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
